dpbram_reader: RTL and testbench
================================

DPBRAM_READER -- requirements
Module: dpbram_reader

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 16, sample width in bits.
REQ-002 The block SHALL have parameter AWIDTH, default 16, DPBRAM address width.
REQ-003 The block SHALL have parameter MEM_SIZE, default 10000, DPBRAM depth in words.
REQ-004 One clock; reset is asynchronous and active-high: clk  in  1  rising-edge clock for all logic.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  one-cycle request to begin a readout.
REQ-007 base_addr  in  AWIDTH  first word address, sampled on accepted start.
REQ-008 length  in  AWIDTH  word count, sampled on accepted start.
REQ-009 ram_addr  out  AWIDTH  address to DPBRAM read port.
REQ-010 ram_ce  out  1  read-port chip enable.
REQ-011 ram_we  out  1  write enable, constant 0.
REQ-012 ram_dout  in  DWIDTH  read data, valid the cycle after ram_ce=1.
REQ-013 m_data  out  DWIDTH  stream data.
REQ-014 m_valid  out  1  stream data valid.
REQ-015 m_ready  in  1  downstream accept.
REQ-016 m_last  out  1  marks the final word of a readout.
REQ-017 busy  out  1  readout in progress.
REQ-018 done  out  1  one-cycle completion pulse.

Function
REQ-019 The FSM SHALL have states IDLE, READ, DRAIN; start is accepted only in IDLE and ignored otherwise.
REQ-020 On start with length=0 the block SHALL pulse done the next cycle, stay in IDLE, and emit no data.
REQ-021 On start with length>0 the block SHALL latch base_addr/length, assert busy next cycle, and enter READ.
REQ-022 In READ, ram_ce SHALL be 1 only when (free skid slots - reads in flight) > 0; each ce advances ram_addr by 1.
REQ-023 ram_addr SHALL wrap from MEM_SIZE-1 to 0; base_addr >= MEM_SIZE SHALL be treated as 0.
REQ-024 After issuing length reads, the FSM SHALL enter DRAIN; in DRAIN it SHALL issue no reads.
REQ-025 Each ram_dout word SHALL be captured into a 2-entry skid buffer the cycle after its ce; no word is lost or duplicated under any m_ready pattern.
REQ-026 A transfer occurs when m_valid and m_ready are both 1; m_data/m_valid/m_last SHALL hold while m_valid=1 and m_ready=0.
REQ-027 m_last SHALL be 1 exactly on the length-th word.
REQ-028 The cycle after the m_last transfer, the block SHALL return to IDLE, drop busy, and pulse done.
REQ-029 With m_ready held 1, throughput SHALL be one word per cycle; first m_valid SHALL appear 2 cycles after start.

Reset
REQ-030 rst SHALL asynchronously force IDLE, flush the skid buffer, and zero ram_addr, ram_ce, m_data, m_valid, m_last, busy, done.
REQ-031 rst asserted mid-readout SHALL abandon the readout with no done pulse; the first start after release SHALL behave as a fresh readout.

Configuration
REQ-032 With DPBRAM_READER_ABORT_EN defined, an input abort SHALL exist; abort=1 in READ/DRAIN SHALL stop reads, flush the skid, clear m_valid next cycle, and pulse done on return to IDLE.
REQ-033 Without DPBRAM_READER_ABORT_EN, the abort port and logic SHALL be absent and readouts run to completion.

Structure
REQ-034 State encoding and the skid depth constant (2) SHALL live in the shared package dpbram_pkg.
REQ-035 The skid buffer SHALL be a sub-module dpbram_rd_skid (2-entry, count output, DWIDTH+1 wide to carry last).

Verification
REQ-036 base=0, length=4, m_ready=1, RAM[0..3]=1,2,3,4 -> data 1,2,3,4 on consecutive cycles, m_last on 4, done once.
REQ-037 base=9998, length=4, MEM_SIZE=10000 -> ram_addr 9998,9999,0,1; data order preserved.
REQ-038 length=8, m_ready toggling 1/0 each cycle -> 8 words in order, no loss or duplication, m_last on word 8.
REQ-039 length=0 start -> done one cycle later, m_valid never 1, busy stays 0.
REQ-040 rst pulsed after 3 of 10 words -> all outputs 0 immediately, no done; a following start with length=2 yields 2 correct words.

Source files
------------

// File: rtl/dpbram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpbram_pkg
// Purpose  : Shared FSM state encoding and skid-buffer sizing for the reader.
// Revision : 1.0
// ============================================================================
package dpbram_pkg;

   localparam int unsigned c_skid_depth = 2;
   localparam int unsigned c_skid_cnt_w = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dpbram_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : dpbram_rd_skid
// Purpose  : Two-entry output skid FIFO; entry 0 is always the stream head.
// Revision : 1.0
// ============================================================================
module dpbram_rd_skid
   import dpbram_pkg::*;
#(
   parameter int WIDTH = 17
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head_data,
   output logic                    head_valid,
   output logic [c_skid_cnt_w-1:0] count
);

   localparam logic [c_skid_cnt_w-1:0] c_full = c_skid_cnt_w'(c_skid_depth);

   logic [WIDTH-1:0]        r_mem0;
   logic [WIDTH-1:0]        r_mem1;
   logic [c_skid_cnt_w-1:0] r_count;
   logic                    w_pop;

   assign w_pop = pop && (r_count != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem0  <= '0;
         r_mem1  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else begin
         case ({push, w_pop})
            2'b10: begin
               if (r_count == '0) begin
                  r_mem0 <= push_data;
               end else begin
                  r_mem1 <= push_data;
               end
               if (r_count != c_full) begin
                  r_count <= r_count + c_skid_cnt_w'(1);
               end
            end
            2'b01: begin
               r_mem0  <= r_mem1;
               r_count <= r_count - c_skid_cnt_w'(1);
            end
            2'b11: begin
               // Occupancy is unchanged; the new word lands behind whatever remains.
               if (r_count == c_skid_cnt_w'(1)) begin
                  r_mem0 <= push_data;
               end else begin
                  r_mem0 <= r_mem1;
                  r_mem1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_data  = r_mem0;
   assign head_valid = (r_count != '0);
   assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/dpbram_reader.sv
`default_nettype none
// ============================================================================
// Module   : dpbram_reader
// Purpose  : Streams a wrapping block of DPBRAM words out on a valid/ready port.
//            Define DPBRAM_READER_ABORT_EN to add the abort input.
// Revision : 1.0
// ============================================================================
module dpbram_reader
   import dpbram_pkg::*;
#(
   parameter int DWIDTH   = 16,
   parameter int AWIDTH   = 16,
   parameter int MEM_SIZE = 10000
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AWIDTH-1:0] base_addr,
   input  logic [AWIDTH-1:0] length,
   output logic [AWIDTH-1:0] ram_addr,
   output logic              ram_ce,
   output logic              ram_we,
   input  logic [DWIDTH-1:0] ram_dout,
   output logic [DWIDTH-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
`ifdef DPBRAM_READER_ABORT_EN
   input  logic              abort,
`endif
   output logic              m_last,
   output logic              busy,
   output logic              done
);

   localparam logic [AWIDTH:0]   c_mem_size  = (AWIDTH+1)'(MEM_SIZE);
   localparam logic [AWIDTH-1:0] c_last_addr = AWIDTH'(MEM_SIZE - 1);

   state_t                  r_state;
   logic [AWIDTH-1:0]       r_addr;
   logic [AWIDTH-1:0]       r_rem;
   logic                    r_pend;
   logic                    r_pend_last;
   logic                    r_busy;
   logic                    r_done;

   logic                    w_abort;
   logic                    w_pop;
   logic                    w_ce;
   logic [2:0]              w_occ;
   logic [2:0]              w_cap;
   logic [c_skid_cnt_w-1:0] w_count;
   logic [DWIDTH:0]         w_head;
   logic                    w_head_valid;

`ifdef DPBRAM_READER_ABORT_EN
   assign w_abort = abort && (r_state != ST_IDLE);
`else
   assign w_abort = 1'b0;
`endif

   // Credit check counts a word leaving this cycle as a free slot, which is
   // what sustains one word per cycle through a two-entry buffer.
   assign w_pop = w_head_valid && m_ready;
   assign w_occ = {1'b0, w_count} + {2'b0, r_pend};
   assign w_cap = 3'(c_skid_depth) + {2'b0, w_pop};
   assign w_ce  = (r_state == ST_READ) && (w_occ < w_cap) && !w_abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_rem       <= '0;
         r_pend      <= 1'b0;
         r_pend_last <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done      <= 1'b0;
         r_pend      <= w_ce;
         r_pend_last <= w_ce && (r_rem == AWIDTH'(1));
         if (w_ce) begin
            r_addr <= (r_addr == c_last_addr) ? '0 : r_addr + AWIDTH'(1);
         end
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (length == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= ST_READ;
                     r_busy  <= 1'b1;
                     r_rem   <= length;
                     r_addr  <= ({1'b0, base_addr} >= c_mem_size) ? '0 : base_addr;
                  end
               end
            end
            ST_READ: begin
               if (w_ce) begin
                  r_rem <= r_rem - AWIDTH'(1);
                  if (r_rem == AWIDTH'(1)) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_pop && w_head[DWIDTH]) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
         if (w_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pend  <= 1'b0;
         end
      end
   end

   dpbram_rd_skid #(
      .WIDTH      (DWIDTH + 1)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .flush      (w_abort),
      .push       (r_pend),
      .push_data  ({r_pend_last, ram_dout}),
      .pop        (w_pop),
      .head_data  (w_head),
      .head_valid (w_head_valid),
      .count      (w_count)
   );

   assign ram_addr = r_addr;
   assign ram_ce   = w_ce;
   assign ram_we   = 1'b0;
   assign m_data   = w_head[DWIDTH-1:0];
   assign m_valid  = w_head_valid;
   assign m_last   = w_head[DWIDTH] && w_head_valid;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dpbram_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpbram_reader
// Purpose  : Directed and randomized readouts checked against an address/data model.
// Revision : 1.0
// ============================================================================
module tb_dpbram_reader;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int MS = 10000;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          start     = 1'b0;
   logic          m_ready   = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] length    = '0;
   logic [DW-1:0] ram_dout  = '0;
   logic [AW-1:0] ram_addr;
   logic          ram_ce;
   logic          ram_we;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_last;
   logic          busy;
   logic          done;
`ifdef DPBRAM_READER_ABORT_EN
   logic          abort = 1'b0;
`endif

   logic [DW-1:0] mem [MS];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   // One-cycle-latency synchronous read port.
   always @(posedge clk) if (ram_ce) ram_dout <= mem[ram_addr];

   dpbram_reader #(
      .DWIDTH    (DW),
      .AWIDTH    (AW),
      .MEM_SIZE  (MS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .ram_addr  (ram_addr),
      .ram_ce    (ram_ce),
      .ram_we    (ram_we),
      .ram_dout  (ram_dout),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
`ifdef DPBRAM_READER_ABORT_EN
      .abort     (abort),
`endif
      .m_last    (m_last),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // mode: 0 = ready always high, 1 = ready toggling, 2 = random ready plus an ignored start.
   // rst_after > 0: assert reset right after that many words have been accepted.
   task automatic run_readout(input int base, input int len, input int mode, input int rst_after);
      int            beff;
      int            got;
      int            done_cnt;
      int            done_cyc;
      int            last_cyc;
      int            first_v;
      int            busy_cyc;
      logic          stall;
      logic [DW-1:0] held;
      logic          held_last;
      logic [AW-1:0] addrs [$];
      beff = (base >= MS) ? 0 : base;
      got = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1; first_v = -1; busy_cyc = 0;
      stall = 1'b0; held = '0; held_last = 1'b0;
      @(negedge clk);
      start = 1'b1; base_addr = AW'(base); length = AW'(len); m_ready = 1'b1;
      for (int cyc = 1; cyc <= 80 + 4 * len; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (m_valid && first_v < 0) first_v = cyc;
         if (busy) busy_cyc++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (stall) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", 32'(m_data), 32'(held));
            check("hold_last", 32'(m_last), 32'(held_last));
         end
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = cyc[0];
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         if (mode == 2 && cyc == 2) begin
            start  = 1'b1;
            length = AW'(len + 3);
         end
         #1;
         if (ram_ce) addrs.push_back(ram_addr);
         if (m_valid && m_ready) begin
            check("data", 32'(m_data), 32'(mem[(beff + got) % MS]));
            check("last", 32'(m_last), 32'(got == len - 1));
            got++;
            if (got == len) last_cyc = cyc;
         end
         stall = m_valid && !m_ready;
         held = m_data;
         held_last = m_last;
         if (rst_after > 0 && got == rst_after) begin
            @(posedge clk);
            #2 rst = 1'b1;
            #1;
            check("rst_ctl", 32'({m_valid, m_last, busy, done, ram_ce}), 32'd0);
            check("rst_data", 32'(m_data), 32'd0);
            check("rst_addr", 32'(ram_addr), 32'd0);
            repeat (3) begin
               @(negedge clk);
               check("rst_no_done", 32'(done), 32'd0);
            end
            rst = 1'b0;
            return;
         end
         if (done_cyc > 0 && cyc >= done_cyc + 2) break;
      end
      check("words", got, len);
      check("done_count", done_cnt, 1);
      check("done_timing", done_cyc, (len == 0) ? 1 : last_cyc + 1);
      check("busy_cycles", busy_cyc, (len == 0) ? 0 : last_cyc);
      check("reads", addrs.size(), len);
      foreach (addrs[i]) begin
         if (i < len) check("ram_addr", 32'(addrs[i]), (beff + i) % MS);
      end
      if (len == 0) check("no_valid", first_v, -1);
      if (mode == 0 && len > 0) begin
         check("latency", first_v, 3);
         check("throughput", last_cyc, len + 2);
      end
   endtask

   initial begin
      foreach (mem[i]) mem[i] = DW'($urandom);
      for (int i = 0; i < 4; i++) mem[i] = DW'(i + 1);

      repeat (3) @(negedge clk);
      check("reset_ctl", 32'({m_valid, m_last, busy, done, ram_ce, ram_we}), 32'd0);
      check("reset_data", 32'(m_data), 32'd0);
      check("reset_addr", 32'(ram_addr), 32'd0);
      rst = 1'b0;

      run_readout(0, 4, 0, -1);
      run_readout(9998, 4, 0, -1);
      run_readout(100, 8, 1, -1);
      run_readout(0, 0, 0, -1);
      run_readout(200, 10, 0, 3);
      run_readout(300, 2, 0, -1);
      run_readout(MS + 5, 3, 2, -1);
      run_readout(9995, 9, 1, -1);

      repeat (8) begin
         int b;
         b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(MS - 12, MS + 40))
                                         : int'($urandom_range(0, MS - 1));
         run_readout(b, int'($urandom_range(1, 12)), int'($urandom_range(0, 2)), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
